// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and constants for the pushbutton conditioner
//
// Purpose: per-channel debounce state encoding, channel index names and the
// default channel count used by button_conditioner and button_channel.
// Ports: none (package).

package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } btn_state_e;

  // Bit positions of the game's buttons in btn_raw and every output vector.
  localparam int BTN_START = 0;
  localparam int BTN_A     = 1;
  localparam int BTN_B     = 2;

  localparam int N_BTN_DEFAULT = 3;

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one pushbutton: synchronizer, debounce FSM, press/release/long pulses
//
// Purpose: conditions a single asynchronous active-high button level.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   raw_i      asynchronous raw button level
//   level_o    debounced level
//   press_o    one-cycle pulse on accepted press
//   release_o  one-cycle pulse on accepted release
//   long_o     one-cycle pulse once a press has been held HOLD_CYCLES clocks

module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  logic             sync1_q;
  logic             sync_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             long_done_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;

  assign cnt_d = cnt_q + CNT_ONE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync_q    <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          level_q     <= 1'b0;
          long_done_q <= 1'b0;
          if (sync_q) begin
            state_q <= WAIT_PRESS;
            cnt_q   <= CNT_ONE;
          end
        end
        WAIT_PRESS: begin
          if (!sync_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        PRESSED: begin
          if (!sync_q) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= CNT_ONE;
          end else if (cnt_q != HOLD_MAX) begin
            // Hold counter saturates; long_done keeps a bounce-restarted
            // hold from firing a second long pulse within one press.
            cnt_q <= cnt_d;
            if (cnt_d == HOLD_MAX && !long_done_q) begin
              long_q      <= 1'b1;
              long_done_q <= 1'b1;
            end
          end
        end
        WAIT_RELEASE: begin
          if (sync_q) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - conditions the Start/BotonA/BotonB pushbuttons for the game FSM
//
// Purpose: N_BTN independent button_channel instances.
// Ports:
//   clock        rising-edge system clock
//   Reset        synchronous active-high reset
//   btn_raw      asynchronous raw button levels (bit 0 Start, 1 BotonA, 2 BotonB)
//   btn_level    debounced levels
//   btn_press    one-cycle pulses on accepted press
//   btn_release  one-cycle pulses on accepted release
//   btn_long     one-cycle pulses after a press is held HOLD_CYCLES clocks

module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_channel (
      .clk_i     (clock),
      .rst_i     (Reset),
      .raw_i     (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g]),
      .long_o    (btn_long[g])
    );
  end

endmodule
